// File: rtl/vec_sqsum_seq.sv
// vec_sqsum_seq: sequences operand-buffer reads into the VecALU sum-of-squares
// unit and accumulates each element-pair result into a scalar Result.
// Build option: define VEC_SQSUM_SAT_EN for unsigned saturating accumulation
// with a sticky Overflow flag; otherwise accumulation wraps and Overflow is 0.
module vec_sqsum_seq #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic [ADDR_W:0]   Len,
    input  logic [ADDR_W-1:0] BaseA,
    input  logic [ADDR_W-1:0] BaseB,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Result,
    output logic              Overflow,
    output logic              RdEn,
    output logic [ADDR_W-1:0] RdAddrA,
    output logic [ADDR_W-1:0] RdAddrB,
    input  logic [DATA_W-1:0] RdDataA,
    input  logic [DATA_W-1:0] RdDataB,
    output logic              Vec_en,
    output logic [DATA_W-1:0] Operand1,
    output logic [DATA_W-1:0] Operand2,
    input  logic [DATA_W-1:0] AluOut
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Remaining reads to issue; the address registers double as the latched bases.
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] addr_a_d, addr_b_d;
    logic              rd_en_d, busy_d, done_d;
    logic [DATA_W-1:0] acc_d;
    logic              ovf_d;
    logic              valid_q;
    logic              accept_c;
    logic [DATA_W-1:0] sum_c;
    logic              ovf_hit_c;

`ifdef VEC_SQSUM_SAT_EN
    logic [DATA_W:0] sum_wide_c;
    assign sum_wide_c = {1'b0, Result} + {1'b0, AluOut};
    assign sum_c      = sum_wide_c[DATA_W] ? {DATA_W{1'b1}} : sum_wide_c[DATA_W-1:0];
    assign ovf_hit_c  = sum_wide_c[DATA_W];
`else
    assign sum_c      = Result + AluOut;
    assign ovf_hit_c  = 1'b0;
`endif

    assign accept_c = (state_q == S_IDLE) && Start;

    // VecALU operands are gated so the unit only sees data on returning beats.
    assign Vec_en   = valid_q;
    assign Operand1 = valid_q ? RdDataA : '0;
    assign Operand2 = valid_q ? RdDataB : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: zero-length starts never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start && (Len != '0)) state_d = S_ISSUE;
            S_ISSUE: if (rem_q == LEN_W'(1))   state_d = S_DRAIN;
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs and datapath.
    always_comb begin
        rem_d    = rem_q;
        addr_a_d = RdAddrA;
        addr_b_d = RdAddrB;
        rd_en_d  = (state_d == S_ISSUE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_q == S_DRAIN) || (accept_c && (Len == '0));
        acc_d    = Result;
        ovf_d    = Overflow;
        if (accept_c) begin
            rem_d    = Len;
            addr_a_d = BaseA;
            addr_b_d = BaseB;
            acc_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (state_q == S_ISSUE) begin
                rem_d = rem_q - LEN_W'(1);
                if (state_d == S_ISSUE) begin
                    addr_a_d = RdAddrA + ADDR_W'(1);
                    addr_b_d = RdAddrB + ADDR_W'(1);
                end
            end
            if (valid_q) begin
                acc_d = sum_c;
                ovf_d = Overflow | ovf_hit_c;
            end
        end
    end

    // Output and datapath registers; read data returns one cycle after RdEn.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            RdEn     <= 1'b0;
            RdAddrA  <= '0;
            RdAddrB  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= '0;
            Overflow <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            RdEn     <= rd_en_d;
            RdAddrA  <= addr_a_d;
            RdAddrB  <= addr_b_d;
            Busy     <= busy_d;
            Done     <= done_d;
            Result   <= acc_d;
            Overflow <= ovf_d;
            valid_q  <= RdEn;
        end
    end

endmodule
